// File: rtl/crc_pkg.sv
// Shared types and widths for the CRC frame loader.
package crc_pkg;
  localparam int CRC_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {RECV, START, WAIT, REPORT} state_t;
endpackage

// File: rtl/crc_frame_loader_if.sv
// Byte-stream valid/ready link into the frame loader.
interface crc_frame_loader_if;
  import crc_pkg::*;
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/crc_frame_ram.sv
// 1W/1R synchronous frame buffer with registered read; read register resets, array does not.
module crc_frame_ram
  import crc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [BYTE_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [BYTE_W-1:0] o_rdata
);
  logic [BYTE_W-1:0] r_mem [2**ADDR_W];
  logic [BYTE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/crc_frame_loader.sv
// Buffers a frame's payload, strips the trailing 2-byte CRC, hands off to crc_system and reports.
module crc_frame_loader
  import crc_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk50m,
  input  logic                 rst,
  crc_frame_loader_if.slave    s_in,
  input  logic [ADDR_W-1:0]    mem_addr,
  output logic [BYTE_W-1:0]    mem_data,
  output logic                 crc_start,
  output logic [CRC_W-1:0]     crc_out_target,
  output logic [ADDR_W:0]      payload_len,
  input  logic                 crc_rdy,
  input  logic                 crc_ok,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic                 frame_err
);
  localparam int CNT_W   = ADDR_W + 1;
  localparam int CNT_MAX = 2**ADDR_W + 3;
  localparam int TMO_W   = $clog2(TIMEOUT_CYC);

  state_t              r_state, w_nxt;
  logic [BYTE_W-1:0]   r_d0, r_d1;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic [CRC_W-1:0]    r_crc_tgt;
  logic [CNT_W-1:0]    r_plen;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_rdy_q;
  logic                r_frame_ok, r_frame_err;

  logic                w_acc, w_has_out, w_ovf_now, w_we, w_last, w_bad, w_edge, w_tmo;
  logic [CNT_W-1:0]    w_waddr;

  // Two bytes of delay keep the CRC trailer out of the buffer; addr bit ADDR_W flags overflow.
  assign w_acc     = s_in.in_valid && s_in.in_ready;
  assign w_has_out = r_cnt >= CNT_W'(2);
  assign w_waddr   = r_cnt - CNT_W'(2);
  assign w_ovf_now = w_acc && w_has_out && w_waddr[ADDR_W];
  assign w_we      = w_acc && w_has_out && !w_waddr[ADDR_W];
  assign w_last    = w_acc && s_in.in_last;
  assign w_bad     = (r_cnt < CNT_W'(2)) || r_ovf || w_ovf_now;
  assign w_edge    = crc_rdy && !r_rdy_q;
  assign w_tmo     = r_tmo == TMO_W'(TIMEOUT_CYC - 1);

  always_comb begin
    w_nxt         = r_state;
    s_in.in_ready = 1'b0;
    crc_start     = 1'b0;
    frame_done    = 1'b0;
    case (r_state)
      RECV: begin
        s_in.in_ready = 1'b1;
        if (w_last) w_nxt = w_bad ? REPORT : START;
      end
      START: begin
        crc_start = 1'b1;
        w_nxt     = WAIT;
      end
      WAIT:   if (w_edge || w_tmo) w_nxt = REPORT;
      REPORT: begin
        frame_done = 1'b1;
        w_nxt      = RECV;
      end
      default: w_nxt = RECV;
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_state     <= RECV;
      r_d0        <= '0;
      r_d1        <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_crc_tgt   <= '0;
      r_plen      <= '0;
      r_tmo       <= '0;
      r_rdy_q     <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_rdy_q <= crc_rdy;
      if (w_acc) begin
        if (s_in.in_last) begin
          r_d0  <= '0;
          r_d1  <= '0;
          r_cnt <= '0;
          r_ovf <= 1'b0;
          if (w_bad) begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b1;
          end else begin
            r_crc_tgt <= {s_in.in_data, r_d1};
            r_plen    <= r_cnt - CNT_W'(1);
          end
        end else begin
          r_d0 <= r_d1;
          r_d1 <= s_in.in_data;
          if (r_cnt != CNT_W'(CNT_MAX)) r_cnt <= r_cnt + CNT_W'(1);
          if (w_ovf_now) r_ovf <= 1'b1;
        end
      end
      if (r_state == START) r_tmo <= '0;
      if (r_state == WAIT) begin
        r_tmo <= r_tmo + TMO_W'(1);
        if (w_edge) begin
          r_frame_ok  <= crc_ok;
          r_frame_err <= 1'b0;
        end else if (w_tmo) begin
          r_frame_ok  <= 1'b0;
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign crc_out_target = r_crc_tgt;
  assign payload_len    = r_plen;
  assign frame_ok       = r_frame_ok;
  assign frame_err      = r_frame_err;

  crc_frame_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk50m),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr[ADDR_W-1:0]),
    .i_wdata (r_d0),
    .i_raddr (mem_addr),
    .o_rdata (mem_data)
  );
endmodule
